ipv4_rx_parser: RTL and testbench

// Parametrised IPv4 receive parser, successor to the fixed-width header extractor.
// - Consumes an MSB-first chunk stream from the Ethernet/MAC stripper.
// - Extracts header fields and skips IHL options.
// - Verifies the ones-complement header checksum.
// - Forwards exactly (total_length - 4*IHL) payload bytes downstream; trailing Ethernet padding is discarded.
// - Sits between the Ethernet RX stage and the UDP RX stage.

---
 rtl/ip_pkg.sv | 35 +++
 rtl/ip_csum_acc.sv | 37 +++
 rtl/ipv4_rx_parser.sv | 186 ++++++++++++++++++
 tb/tb_ipv4_rx_parser.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared definitions for the IPv4 receive path.
// Provides the parser state encoding, error codes, protocol constants,
// header byte offsets and the ones-complement fold helper.
package ip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DRAIN
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_HDR   = 2'd1;  // bad version, IHL or total_length
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_TRUNC = 2'd3;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IPV4_MIN_IHL = 4'd5;

  localparam logic [15:0] OFF_LEN_HI  = 16'd2;
  localparam logic [15:0] OFF_LEN_LO  = 16'd3;
  localparam logic [15:0] OFF_PROTO   = 16'd9;
  localparam logic [15:0] OFF_SRC     = 16'd12;
  localparam logic [15:0] OFF_SRC_END = 16'd15;
  localparam logic [15:0] OFF_DST     = 16'd16;
  localparam logic [15:0] OFF_DST_END = 16'd19;

  // Fold the end-around carry of a 17-bit ones-complement sum back into 16 bits.
  // A folded 16-bit value plus a 16-bit word can never carry twice.
  function automatic logic [15:0] csum_fold(input logic [16:0] s);
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones-complement 16-bit word accumulator (IPv4/UDP header checksum).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero the accumulator (takes priority over word_valid)
//   word_valid   add word this cycle
//   word[15:0]   16-bit big-endian word
//   ok           folded sum, including the word presented this cycle, equals 16'hFFFF
// ok looks ahead by one word so the caller can decide on the same cycle
// as the final header word instead of one cycle later.
module ip_csum_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic        ok
);

  logic [15:0] sum_q, sum_d;
  logic [16:0] raw;

  always_comb begin
    raw   = {1'b0, sum_q} + {1'b0, word};
    sum_d = sum_q;
    if (clear)           sum_d = 16'd0;
    else if (word_valid) sum_d = csum_fold(raw);
    ok = (sum_d == 16'hFFFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= 16'd0;
    else        sum_q <= sum_d;
  end

endmodule

// File: rtl/ipv4_rx_parser.sv
// IPv4 receive parser: header field extraction, option skip, header
// checksum verification and payload forwarding for an MSB-first N-bit
// chunk stream.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   axiiv, axiid        input chunk valid (high for whole frame) / data
//   axiov, axiod        payload chunk valid / data, one cycle latency
//   hdr_valid           1-cycle pulse: header accepted
//   err, err_code       1-cycle error pulse / code held until next error
//   src_ip_out, dst_ip_out, protocol_out, packet_length_out
//                       header fields, updated only on hdr_valid
module ipv4_rx_parser
  import ip_pkg::*;
#(
  parameter int N           = 4,
  parameter bit CHECK_CSUM  = 1'b1,
  parameter bit DROP_ON_ERR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          axiiv,
  input  logic [N-1:0]  axiid,
  output logic          axiov,
  output logic [N-1:0]  axiod,
  output logic          hdr_valid,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [31:0]   src_ip_out,
  output logic [31:0]   dst_ip_out,
  output logic [7:0]    protocol_out,
  output logic [15:0]   packet_length_out
);

  localparam int CPB   = 8 / N;           // chunks per byte
  localparam int SH    = $clog2(CPB);
  localparam int CNT_W = 16 + SH;         // chunk count spanning 65535 bytes

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]  byte_sr_q, hi_q, proto_q;
  logic [3:0]  ihl_q;
  logic [15:0] len_q;
  logic [31:0] src_q, dst_q;

  logic          axiov_q, hdr_valid_q, err_q;
  logic [N-1:0]  axiod_q;
  logic [1:0]    err_code_q;
  logic [31:0]   src_out_q, dst_out_q;
  logic [7:0]    proto_out_q;
  logic [15:0]   len_out_q;

  logic [7:0]  cur_byte;
  logic [15:0] byte_idx, hdr_len, hdr_last, len_full;
  logic [31:0] dst_full;
  logic        last_of_byte, hdr_byte, hdr_ok, csum_ok, csum_good, word_valid;
  logic        err_d, hdr_valid_d, fwd;
  logic [1:0]  err_code_d;

  // The byte being completed by this chunk (only meaningful when last_of_byte).
  assign cur_byte     = 8'(byte_sr_q << N) | 8'(axiid);
  assign byte_idx     = cnt_q[CNT_W-1:SH];
  assign last_of_byte = (cnt_q & CNT_W'(CPB - 1)) == CNT_W'(CPB - 1);
  assign hdr_byte     = axiiv && (state_q == IDLE || state_q == HDR) && last_of_byte;
  assign hdr_len      = {10'd0, ihl_q, 2'b00};
  assign hdr_last     = hdr_len - 16'd1;
  assign len_full     = {len_q[7:0], cur_byte};
  assign hdr_ok       = (cur_byte[7:4] == IPV4_VERSION) && (cur_byte[3:0] >= IPV4_MIN_IHL);
  // With IHL=5 the last destination byte is still in flight on the decision cycle.
  assign dst_full     = (byte_idx == OFF_DST_END) ? {dst_q[23:0], cur_byte} : dst_q;
  assign word_valid   = hdr_byte && byte_idx[0];
  assign csum_good    = !CHECK_CSUM || csum_ok;

  ip_csum_acc u_csum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!axiiv),
    .word_valid (word_valid),
    .word       ({hi_q, cur_byte}),
    .ok         (csum_ok)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    hdr_valid_d = 1'b0;
    fwd         = 1'b0;

    unique case (state_q)
      IDLE: if (axiiv) state_d = HDR;
      HDR: if (!axiiv) begin
        err_d = 1'b1; err_code_d = ERR_TRUNC; state_d = IDLE;
      end
      PAYLOAD: begin
        if (!axiiv) begin
          err_d = 1'b1; err_code_d = ERR_TRUNC; state_d = IDLE;
        end else begin
          fwd = 1'b1;
          if (last_of_byte && byte_idx == len_q - 16'd1) state_d = DRAIN;
        end
      end
      DRAIN: if (!axiiv) state_d = IDLE;
    endcase

    // Header decisions override the plain transitions above; byte 0 can
    // complete while still in IDLE when N=8.
    if (hdr_byte) begin
      if (byte_idx == 16'd0 && !hdr_ok) begin
        err_d = 1'b1; err_code_d = ERR_HDR; state_d = DRAIN;
      end else if (byte_idx == OFF_LEN_LO && len_full < hdr_len) begin
        err_d = 1'b1; err_code_d = ERR_HDR; state_d = DRAIN;
      end else if (byte_idx == hdr_last) begin
        if (csum_good) begin
          hdr_valid_d = 1'b1;
          state_d     = (len_q == hdr_len) ? DRAIN : PAYLOAD;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_CSUM;
          state_d    = (DROP_ON_ERR || len_q == hdr_len) ? DRAIN : PAYLOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      byte_sr_q   <= 8'd0;
      hi_q        <= 8'd0;
      ihl_q       <= 4'd0;
      len_q       <= 16'd0;
      proto_q     <= 8'd0;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
      axiov_q     <= 1'b0;
      axiod_q     <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      src_out_q   <= 32'd0;
      dst_out_q   <= 32'd0;
      proto_out_q <= 8'd0;
      len_out_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (!axiiv)                     cnt_q <= '0;
      else if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      if (axiiv) byte_sr_q <= cur_byte;

      if (hdr_byte) begin
        if (!byte_idx[0])                                  hi_q    <= cur_byte;
        if (byte_idx == 16'd0)                             ihl_q   <= cur_byte[3:0];
        if (byte_idx == OFF_LEN_HI || byte_idx == OFF_LEN_LO) len_q <= len_full;
        if (byte_idx == OFF_PROTO)                         proto_q <= cur_byte;
        if (byte_idx >= OFF_SRC && byte_idx <= OFF_SRC_END) src_q  <= {src_q[23:0], cur_byte};
        if (byte_idx >= OFF_DST && byte_idx <= OFF_DST_END) dst_q  <= {dst_q[23:0], cur_byte};
      end

      axiov_q <= fwd;
      if (fwd) axiod_q <= axiid;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      if (hdr_valid_d) begin
        src_out_q   <= src_q;
        dst_out_q   <= dst_full;
        proto_out_q <= proto_q;
        len_out_q   <= len_q;
      end
    end
  end

  assign axiov             = axiov_q;
  assign axiod             = axiod_q;
  assign hdr_valid         = hdr_valid_q;
  assign err               = err_q;
  assign err_code          = err_code_q;
  assign src_ip_out        = src_out_q;
  assign dst_ip_out        = dst_out_q;
  assign protocol_out      = proto_out_q;
  assign packet_length_out = len_out_q;

endmodule

// File: tb/tb_ipv4_rx_parser.sv
// Directed bench for ipv4_rx_parser at N=2, 4 and 8. Payload bytes expected
// downstream are queued as frames are driven and compared with the bytes
// the monitor reassembles from axiov/axiod.
module tb_ipv4_rx_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       drv_v = 1'b0;
  logic [7:0] drv_d = 8'd0;
  int         cur_n = 4;
  logic       v2, v4, v8;
  assign v2 = drv_v && cur_n == 2;
  assign v4 = drv_v && cur_n == 4;
  assign v8 = drv_v && cur_n == 8;

  logic o2_ov, o4_ov, o8_ov, o2_hv, o4_hv, o8_hv, o2_er, o4_er, o8_er;
  logic [1:0]  o2_d, o2_ec, o4_ec, o8_ec;
  logic [3:0]  o4_d;
  logic [7:0]  o8_d, o2_pr, o4_pr, o8_pr;
  logic [31:0] o2_src, o4_src, o8_src, o2_dst, o4_dst, o8_dst;
  logic [15:0] o2_len, o4_len, o8_len;

  ipv4_rx_parser #(.N(2)) u2 (.clk(clk), .rst_n(rst_n), .axiiv(v2), .axiid(drv_d[1:0]),
    .axiov(o2_ov), .axiod(o2_d), .hdr_valid(o2_hv), .err(o2_er), .err_code(o2_ec),
    .src_ip_out(o2_src), .dst_ip_out(o2_dst), .protocol_out(o2_pr), .packet_length_out(o2_len));
  ipv4_rx_parser #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .axiiv(v4), .axiid(drv_d[3:0]),
    .axiov(o4_ov), .axiod(o4_d), .hdr_valid(o4_hv), .err(o4_er), .err_code(o4_ec),
    .src_ip_out(o4_src), .dst_ip_out(o4_dst), .protocol_out(o4_pr), .packet_length_out(o4_len));
  ipv4_rx_parser #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .axiiv(v8), .axiid(drv_d),
    .axiov(o8_ov), .axiod(o8_d), .hdr_valid(o8_hv), .err(o8_er), .err_code(o8_ec),
    .src_ip_out(o8_src), .dst_ip_out(o8_dst), .protocol_out(o8_pr), .packet_length_out(o8_len));

  logic        mon_ov, mon_hv, mon_er;
  logic [7:0]  mon_d, mon_pr, mon_nb;
  logic [1:0]  mon_ec;
  logic [31:0] mon_src, mon_dst;
  logic [15:0] mon_len;

  always_comb begin
    case (cur_n)
      2: {mon_ov, mon_d, mon_hv, mon_er, mon_ec, mon_src, mon_dst, mon_pr, mon_len} =
         {o2_ov, 6'd0, o2_d, o2_hv, o2_er, o2_ec, o2_src, o2_dst, o2_pr, o2_len};
      8: {mon_ov, mon_d, mon_hv, mon_er, mon_ec, mon_src, mon_dst, mon_pr, mon_len} =
         {o8_ov, o8_d, o8_hv, o8_er, o8_ec, o8_src, o8_dst, o8_pr, o8_len};
      default: {mon_ov, mon_d, mon_hv, mon_er, mon_ec, mon_src, mon_dst, mon_pr, mon_len} =
         {o4_ov, 4'd0, o4_d, o4_hv, o4_er, o4_ec, o4_src, o4_dst, o4_pr, o4_len};
    endcase
  end

  // Monitor: reassembles forwarded bytes and counts pulses.
  int         cyc = 0, chunks = 0, hv_cnt = 0, err_cnt = 0, hv_cyc = 0, ph = 0;
  logic [7:0] acc = 8'd0;
  logic [7:0] rx_q[$];
  assign mon_nb = 8'(acc << cur_n) | mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mon_ov) begin
        chunks <= chunks + 1;
        if (ph == 8 / cur_n - 1) begin
          rx_q.push_back(mon_nb);
          ph  <= 0;
          acc <= 8'd0;
        end else begin
          ph  <= ph + 1;
          acc <= mon_nb;
        end
      end
      if (mon_hv) begin
        hv_cnt <= hv_cnt + 1;
        hv_cyc <= cyc;
      end
      if (mon_er) err_cnt <= err_cnt + 1;
    end
  end

  // Stimulus side
  int         total = 0, bad = 0;
  logic [7:0] frm[$];
  logic [7:0] exp_q[$];
  int         cmp_rd = 0, t_hdr_end = 0, hv0 = 0, err0 = 0, ch0 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    drv_v = 1'b0;
    drv_d = 8'd0;
    repeat (k) tick();
  endtask

  task automatic snap();
    hv0  = hv_cnt;
    err0 = err_cnt;
    ch0  = chunks;
  endtask

  // Frame: header (checksum computed here), options 01.., payload i*7+3, padding A5.
  task automatic build(input int ver, input int ihl, input int npay, input int pad, input bit corrupt);
    int hl = 4 * ihl;
    int len = hl + npay;
    int s = 0;
    logic [15:0] cs;
    frm.delete();
    frm.push_back(8'((ver << 4) | ihl)); frm.push_back(8'h00);
    frm.push_back(8'(len >> 8));         frm.push_back(8'(len));
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'hC7);
    for (int i = 20; i < hl; i++) frm.push_back(8'h01);
    for (int i = 0; i < hl; i += 2) s += {frm[i], frm[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~16'(s);
    frm[10] = cs[15:8] + (corrupt ? 8'd1 : 8'd0);
    frm[11] = cs[7:0];
    for (int i = 0; i < npay; i++) frm.push_back(8'(i * 7 + 3));
    for (int i = 0; i < pad; i++) frm.push_back(8'hA5);
  endtask

  // Drive bytes 0..nbytes-1; queue payload bytes [hl, len) when forwarding is expected.
  task automatic send(input int nbytes, input int hl, input int len, input bit fwd);
    int cpb = 8 / cur_n;
    for (int b = 0; b < nbytes; b++) begin
      if (fwd && b >= hl && b < len) exp_q.push_back(frm[b]);
      for (int c = 0; c < cpb; c++) begin
        drv_v = 1'b1;
        drv_d = 8'((frm[b] >> (8 - cur_n * (c + 1))) & ((1 << cur_n) - 1));
        if (b == hl - 1 && c == cpb - 1) t_hdr_end = cyc;
        tick();
      end
    end
  endtask

  task automatic cmp_payload(input string tag);
    check({tag, "_bytes"}, rx_q.size(), exp_q.size());
    for (int i = cmp_rd; i < exp_q.size() && i < rx_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
    cmp_rd = exp_q.size();
  endtask

  task automatic good_frame(input string tag);
    build(4, 5, 95, 0, 1'b0);
    snap();
    send(115, 20, 115, 1'b1);
    idle(4);
    check({tag, "_hv"}, hv_cnt - hv0, 1);
    check({tag, "_err"}, err_cnt - err0, 0);
    cmp_payload({tag, "_pay"});
  endtask

  initial begin
    #22;
    for (int n = 2; n <= 8; n *= 2) begin
      cur_n = n;
      #1;
      check("rst_ctl", {mon_ov, mon_hv, mon_er, mon_ec}, 5'd0);
      check("rst_ip", {mon_src, mon_dst}, 64'd0);
      check("rst_pl", {mon_pr, mon_len}, 24'd0);
    end
    cur_n = 4;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Reference frame, N=4
    build(4, 5, 95, 0, 1'b0);
    snap();
    send(115, 20, 115, 1'b1);
    idle(4);
    check("n4_hv", hv_cnt - hv0, 1);
    check("n4_hv_lat", hv_cyc, t_hdr_end + 1);
    check("n4_err", err_cnt - err0, 0);
    check("n4_src", mon_src, 32'hC0A80001);
    check("n4_dst", mon_dst, 32'hC0A800C7);
    check("n4_len", mon_len, 16'd115);
    check("n4_proto", mon_pr, 8'h11);
    check("n4_chunks", chunks - ch0, 190);
    cmp_payload("n4_pay");

    // Checksum byte B8 -> B9: dropped, fields held
    build(4, 5, 95, 0, 1'b1);
    snap();
    send(115, 20, 115, 1'b0);
    idle(4);
    check("cs_err", err_cnt - err0, 1);
    check("cs_code", mon_ec, 2'd2);
    check("cs_hv", hv_cnt - hv0, 0);
    check("cs_chunks", chunks - ch0, 0);
    check("cs_src_held", mon_src, 32'hC0A80001);
    check("cs_len_held", mon_len, 16'd115);

    // N=2 and N=8 with 10 padding bytes
    for (int n = 2; n <= 8; n += 6) begin
      cur_n = n;
      idle(2);
      build(4, 5, 95, 10, 1'b0);
      snap();
      send(125, 20, 115, 1'b1);
      idle(4);
      check("wn_hv", hv_cnt - hv0, 1);
      check("wn_hv_lat", hv_cyc, t_hdr_end + 1);
      check("wn_err", err_cnt - err0, 0);
      check("wn_fields", {mon_src, mon_dst}, {32'hC0A80001, 32'hC0A800C7});
      check("wn_len_proto", {mon_len, mon_pr}, {16'd115, 8'h11});
      check("wn_chunks", chunks - ch0, 95 * 8 / n);
      cmp_payload("wn_pay");
    end
    cur_n = 4;
    idle(2);

    // IHL=6 with one option word
    build(4, 6, 95, 0, 1'b0);
    snap();
    send(119, 24, 119, 1'b1);
    idle(4);
    check("opt_hv", hv_cnt - hv0, 1);
    check("opt_hv_lat", hv_cyc, t_hdr_end + 1);
    check("opt_len", mon_len, 16'd119);
    check("opt_chunks", chunks - ch0, 190);
    cmp_payload("opt_pay");

    // Truncated in the header after byte 10
    build(4, 5, 95, 0, 1'b0);
    snap();
    send(11, 20, 115, 1'b0);
    idle(4);
    check("trh_err", err_cnt - err0, 1);
    check("trh_code", mon_ec, 2'd3);
    check("trh_hv", hv_cnt - hv0, 0);
    good_frame("trh_next");

    // Truncated at payload byte 50
    build(4, 5, 95, 0, 1'b0);
    snap();
    send(70, 20, 115, 1'b1);
    idle(4);
    check("trp_err", err_cnt - err0, 1);
    check("trp_code", mon_ec, 2'd3);
    check("trp_hv", hv_cnt - hv0, 1);
    check("trp_chunks", chunks - ch0, 100);
    cmp_payload("trp_pay");
    good_frame("trp_next");

    // Version 6: header error, frame drained to its end
    build(6, 5, 95, 0, 1'b0);
    snap();
    send(115, 20, 115, 1'b0);
    idle(4);
    check("ver_err", err_cnt - err0, 1);
    check("ver_code", mon_ec, 2'd1);
    check("ver_hv", hv_cnt - hv0, 0);
    check("ver_chunks", chunks - ch0, 0);
    good_frame("ver_next");

    // Reset pulsed mid-payload, input still valid
    build(4, 5, 95, 0, 1'b0);
    snap();
    send(40, 20, 115, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mr_ctl", {mon_ov, mon_d, mon_hv, mon_er, mon_ec}, 13'd0);
    check("mr_ip", {mon_src, mon_dst}, 64'd0);
    check("mr_pl", {mon_pr, mon_len}, 24'd0);
    drv_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("mr_err", err_cnt - err0, 0);
    cmp_payload("mr_pay");
    good_frame("mr_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
